// File: rtl/keypad_password_entry.sv
// rtl/keypad_password_entry.sv - keypad digit collector and BCD-to-binary code converter
//
// Collects DIGITS decimal key presses, converts the code to binary most significant
// digit first, and presents it on password_out with a one-cycle password_valid strobe.
// Optional feature macro: KEYPAD_LOCKOUT_EN (alarm_in blocks keys and aborts entry).
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high
//   key_valid      one-cycle strobe per key press
//   key_code       0-9 digit, 0xA CLEAR, 0xB ENTER, 0xC BACKSPACE, 0xD-0xF ignored
//   alarm_in       alarm from door_control (only used with KEYPAD_LOCKOUT_EN)
//   password_out   last converted code, held between sends
//   password_valid one-cycle pulse with each password_out update
//   entry_active   high while collecting or converting
//   digit_count    digits currently buffered
//   entry_error    high while in the error hold
module keypad_password_entry #(
  parameter int DIGITS         = 4,
  parameter int WIDTH          = 14,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int ERR_HOLD       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  input  logic             alarm_in,
  output logic [WIDTH-1:0] password_out,
  output logic             password_valid,
  output logic             entry_active,
  output logic [2:0]       digit_count,
  output logic             entry_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ENTRY   = 2'd1;
  localparam logic [1:0] S_CONVERT = 2'd2;
  localparam logic [1:0] S_ERROR   = 2'd3;

  localparam logic [3:0] K_CLEAR = 4'hA;
  localparam logic [3:0] K_ENTER = 4'hB;
  localparam logic [3:0] K_BACK  = 4'hC;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int EW = $clog2(ERR_HOLD) + 1;

  localparam logic [2:0]    DIGITS_C = 3'(DIGITS);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [EW-1:0] EMAX     = EW'(ERR_HOLD - 1);

  logic [1:0]          state_q, state_d;
  logic [4*DIGITS-1:0] buf_q, buf_d;      // BCD digit i at bits [4i+3:4i], i=0 first typed
  logic [2:0]          cnt_q, cnt_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [EW-1:0]       err_q, err_d;
  logic [2:0]          idx_q, idx_d;
  logic [WIDTH-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0]    pw_q, pw_d;
  logic                pv_q, pv_d;

  logic       key_ok;
  logic       abort;
  logic       is_digit;
  logic [3:0] digit_sel;

`ifdef KEYPAD_LOCKOUT_EN
  logic alarm_q;

  // Keys are ignored during alarm; a fresh alarm throws away a partial entry.
  assign key_ok = key_valid & ~alarm_in;
  assign abort  = alarm_in & ~alarm_q;

  always_ff @(posedge clk) begin
    if (reset) alarm_q <= 1'b0;
    else       alarm_q <= alarm_in;
  end
`else
  logic alarm_unused;

  assign alarm_unused = alarm_in;
  assign key_ok       = key_valid;
  assign abort        = 1'b0;
`endif

  assign is_digit  = (key_code <= 4'd9);
  // idx_q < DIGITS <= 4 whenever the selected digit is consumed
  assign digit_sel = buf_q[4*idx_q[1:0] +: 4];

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    err_d   = err_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    pw_d    = pw_q;
    pv_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (key_ok && is_digit) begin
          buf_d      = '0;
          buf_d[3:0] = key_code;
          cnt_d      = 3'd1;
          timer_d    = '0;
          state_d    = S_ENTRY;
        end
      end
      S_ENTRY: begin
        if (abort) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (key_ok && key_code <= K_BACK) begin
          // A recognised key beats a timeout expiring on the same cycle.
          timer_d = '0;
          if (is_digit) begin
            if (cnt_q < DIGITS_C) begin
              buf_d[4*cnt_q[1:0] +: 4] = key_code;
              cnt_d = cnt_q + 3'd1;
            end else begin
              state_d = S_ERROR;
              err_d   = '0;
              cnt_d   = '0;
            end
          end else if (key_code == K_CLEAR) begin
            state_d = S_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
          end else if (key_code == K_ENTER) begin
            if (cnt_q == DIGITS_C) begin
              state_d = S_CONVERT;
              idx_d   = '0;
              acc_d   = '0;
            end else begin
              state_d = S_ERROR;
              err_d   = '0;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - 3'd1;
            if (cnt_q == 3'd1) begin
              state_d = S_IDLE;
              buf_d   = '0;
            end
          end
        end else if (timer_q == TMAX) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_CONVERT: begin
        // DIGITS accumulate cycles, then one publish cycle: DIGITS+1 after ENTER.
        if (idx_q == DIGITS_C) begin
          pw_d    = acc_q;
          pv_d    = 1'b1;
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else begin
          acc_d = (acc_q << 3) + (acc_q << 1) + WIDTH'(digit_sel);
          idx_d = idx_q + 3'd1;
        end
      end
      default: begin
        if (err_q == EMAX) begin
          state_d = S_IDLE;
          buf_d   = '0;
        end else begin
          err_d = err_q + EW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
      timer_q <= '0;
      err_q   <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      pw_q    <= '0;
      pv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      err_q   <= err_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      pw_q    <= pw_d;
      pv_q    <= pv_d;
    end
  end

  assign password_out   = pw_q;
  assign password_valid = pv_q;
  assign entry_active   = (state_q == S_ENTRY) || (state_q == S_CONVERT);
  assign digit_count    = cnt_q;
  assign entry_error    = (state_q == S_ERROR);

endmodule

// File: tb/tb_keypad_password_entry.sv
// tb/tb_keypad_password_entry.sv - self-checking bench for keypad_password_entry
module tb_keypad_password_entry;

  localparam int DIGITS         = 4;
  localparam int WIDTH          = 14;
  localparam int TIMEOUT_CYCLES = 1000;
  localparam int ERR_HOLD       = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             key_valid;
  logic [3:0]       key_code;
  logic             alarm_in;
  logic [WIDTH-1:0] password_out;
  logic             password_valid;
  logic             entry_active;
  logic [2:0]       digit_count;
  logic             entry_error;

  keypad_password_entry #(
    .DIGITS(DIGITS), .WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .ERR_HOLD(ERR_HOLD)
  ) dut (
    .clk(clk), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .alarm_in(alarm_in), .password_out(password_out), .password_valid(password_valid),
    .entry_active(entry_active), .digit_count(digit_count), .entry_error(entry_error)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a digit queue plus a few countdowns.
  typedef enum int {M_IDLE, M_TYPING, M_CRUNCH, M_LOCKED} mmode_t;
  mmode_t m_mode = M_IDLE;
  int     m_q[$];
  int     m_quiet;
  int     m_left;
  int     m_value;
  int     m_pw = 0;
  bit     m_pulse = 0;
  bit     m_prev_alarm = 0;

  function automatic int code_value();
    int v = 0;
    foreach (m_q[i]) v += m_q[i] * (10 ** (DIGITS - 1 - i));
    return v;
  endfunction

  task automatic m_to_idle();
    m_mode = M_IDLE;
    m_q.delete();
  endtask

  task automatic m_to_locked();
    m_mode = M_LOCKED;
    m_left = ERR_HOLD;
    m_q.delete();
  endtask

  task automatic model_step();
    bit acc_key;
    bit rise;
    int k;
    if (reset) begin
      m_to_idle();
      m_pw = 0;
      m_pulse = 0;
      m_prev_alarm = 0;
    end else begin
`ifdef KEYPAD_LOCKOUT_EN
      acc_key = key_valid && !alarm_in;
      rise    = alarm_in && !m_prev_alarm;
`else
      acc_key = key_valid;
      rise    = 1'b0;
`endif
      m_prev_alarm = alarm_in;
      k = int'(key_code);
      m_pulse = 0;
      case (m_mode)
        M_IDLE: if (acc_key && k <= 9) begin
          m_q.delete();
          m_q.push_back(k);
          m_quiet = 0;
          m_mode = M_TYPING;
        end
        M_TYPING: begin
          if (rise) m_to_idle();
          else if (acc_key && k <= 12) begin
            m_quiet = 0;
            if (k <= 9) begin
              if (m_q.size() < DIGITS) m_q.push_back(k);
              else m_to_locked();
            end else if (k == 10) m_to_idle();
            else if (k == 11) begin
              if (m_q.size() == DIGITS) begin
                m_value = code_value();
                m_left  = DIGITS + 1;
                m_mode  = M_CRUNCH;
              end else m_to_locked();
            end else begin
              void'(m_q.pop_back());
              if (m_q.size() == 0) m_to_idle();
            end
          end else begin
            m_quiet++;
            if (m_quiet == TIMEOUT_CYCLES) m_to_idle();
          end
        end
        M_CRUNCH: begin
          m_left--;
          if (m_left == 0) begin
            m_pw = m_value;
            m_pulse = 1;
            m_to_idle();
          end
        end
        default: begin
          m_left--;
          if (m_left == 0) m_to_idle();
        end
      endcase
    end
  endtask

  task automatic cyc(input logic kv, input logic [3:0] kc);
    bit busy;
    key_valid = kv;
    key_code  = kc;
    @(posedge clk);
    model_step();
    #1;
    busy = (m_mode == M_TYPING) || (m_mode == M_CRUNCH);
    chk("valid",  password_valid, m_pulse);
    chk("pw",     password_out,   m_pw);
    chk("active", entry_active,   busy);
    chk("count",  digit_count,    busy ? m_q.size() : 0);
    chk("error",  entry_error,    m_mode == M_LOCKED);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0);
  endtask

  int lat, pulses, errs, r;
  logic [3:0] kc;

  initial begin
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; alarm_in = 1'b0;
    cyc(0, 0); cyc(0, 0);
    reset = 1'b0;
    chk("rst_pw", password_out, 0);
    chk("rst_active", entry_active, 0);
    chk("rst_count", digit_count, 0);

    // 1111 and ENTER-to-strobe latency
    for (int i = 0; i < 4; i++) cyc(1, 4'h1);
    cyc(1, 4'hB);
    lat = 0; pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(0, 0);
      if (password_valid) begin
        pulses++;
        if (lat == 0) lat = i;
      end
    end
    chk("latency", lat, DIGITS + 1);
    chk("pulse_count", pulses, 1);
    chk("pw_1111", password_out, 1111);
    chk("done_count", digit_count, 0);
    chk("done_active", entry_active, 0);

    // backspace, and a key during conversion
    cyc(1, 4'h2); cyc(1, 4'h2); cyc(1, 4'h2); cyc(1, 4'h9);
    cyc(1, 4'hC); cyc(1, 4'h2); cyc(1, 4'hB);
    cyc(0, 0); cyc(1, 4'h7);
    idle(10);
    chk("pw_2222", password_out, 2222);
    chk("drop_convert", digit_count, 0);

    // short entry -> error hold; fifth digit -> overflow
    cyc(1, 4'h3); cyc(1, 4'h3); cyc(1, 4'hB);
    errs = entry_error ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0);
      if (entry_error) errs++;
    end
    chk("err_len", errs, ERR_HOLD);
    chk("pw_hold", password_out, 2222);
    for (int d = 1; d <= 4; d++) cyc(1, 4'(d));
    chk("four_ok", entry_error, 0);
    cyc(1, 4'h5);
    chk("overflow", entry_error, 1);
    idle(12);

    // inter-key timeout and key on the expiry cycle
    cyc(1, 4'h5);
    idle(TIMEOUT_CYCLES - 1);
    chk("pre_expiry", entry_active, 1);
    cyc(1, 4'h6);
    chk("expiry_key", digit_count, 2);
    idle(TIMEOUT_CYCLES - 1);
    chk("timer_restart", entry_active, 1);
    cyc(0, 0);
    chk("timeout", entry_active, 0);
    chk("timeout_err", entry_error, 0);

    // reset mid-entry, then CLEAR in IDLE
    cyc(1, 4'h9); cyc(1, 4'h9);
    reset = 1'b1;
    cyc(0, 0);
    reset = 1'b0;
    chk("midrst_pw", password_out, 0);
    chk("midrst_count", digit_count, 0);
    chk("midrst_valid", password_valid, 0);
    cyc(1, 4'hA);
    chk("clear_idle", entry_active, 0);

    // alarm handling
    cyc(1, 4'h4); cyc(1, 4'h4);
    alarm_in = 1'b1;
    cyc(0, 0);
    cyc(1, 4'hA);
    for (int i = 0; i < 4; i++) cyc(1, 4'h1);
    cyc(1, 4'hB);
    idle(10);
    alarm_in = 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
    chk("alarm_pw", password_out, 0);
`else
    chk("alarm_pw", password_out, 1111);
`endif
    idle(2);

    // randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 199) == 0) alarm_in = ~alarm_in;
      r = $urandom_range(0, 19);
      if (r < 12)       kc = 4'(r % 10);
      else if (r < 14)  kc = 4'hB;
      else if (r == 14) kc = 4'hC;
      else if (r == 15) kc = 4'hA;
      else if (r < 19)  kc = 4'(13 + r - 16);
      else              kc = 4'hB;
      cyc($urandom_range(0, 2) == 0, kc);
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
